max_reg_loader: RTL and testbench

- Producer and collector for the 8-input maximum-finder register stage.
- Accepts a stream of 32-bit words over a valid/ready handshake and fills eight output registers in order.
- Once all eight are loaded, it pulses the finder's enable for one cycle, captures the finder's result, and presents it on a valid/ready result port.
- Sits between the upstream data source and the max-finder stage, and owns all sequencing around it.

---
 rtl/max_reg_loader.sv | 135 +++++++++++++
 tb/tb_max_reg_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/max_reg_loader.sv
// -----------------------------------------------------------------------------
// max_reg_loader
//   Producer/collector wrapped around the 8-input maximum-finder stage.
//   Collects eight DATA_W words over a valid/ready handshake into reg_out0..7
//   (the finder inputs), pulses op_enable for one cycle, captures op_result on
//   the following cycle and holds it on a valid/ready result port until taken.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data is the offered word
//   reg_out0..reg_out7    loaded registers, wired to finder inputs 0..7
//   op_enable             one-cycle finder enable (high in FIRE only)
//   op_result             finder result, registered inside the finder
//   res_valid/res_ready   result handshake, res_data is the captured result
//   busy                  high whenever the block is not in LOAD
//
// Optional feature (macro REG_READBACK_EN)
//   Adds rd_addr / rd_data: side-effect-free combinational readback of
//   reg_out[rd_addr], usable in every state. Without the macro, neither the
//   ports nor the mux exist.
// -----------------------------------------------------------------------------
module max_reg_loader #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] reg_out0,
    output logic [DATA_W-1:0] reg_out1,
    output logic [DATA_W-1:0] reg_out2,
    output logic [DATA_W-1:0] reg_out3,
    output logic [DATA_W-1:0] reg_out4,
    output logic [DATA_W-1:0] reg_out5,
    output logic [DATA_W-1:0] reg_out6,
    output logic [DATA_W-1:0] reg_out7,
    output logic              op_enable,
    input  logic [DATA_W-1:0] op_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
`ifdef REG_READBACK_EN
    ,
    input  logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
`endif
);

    typedef enum logic [1:0] {LOAD, FIRE, WAIT, DONE} state_t;

    state_t                   state, nextState;
    logic [2:0]               cnt;
    logic [7:0][DATA_W-1:0]   regs;
    logic [DATA_W-1:0]        resData;
    logic                     resValid;
    logic                     accept;

    // Handshake depends only on state for the ready half, so no
    // combinational path reaches in_ready from any input.
    assign accept = in_valid && (state == LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        op_enable = 1'b0;
        busy      = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && cnt == 3'd7) nextState = FIRE;
            end
            FIRE: begin
                op_enable = 1'b1;
                nextState = WAIT;
            end
            WAIT: nextState = DONE;
            DONE: if (res_ready) nextState = LOAD;
            default: nextState = LOAD;
        endcase
    end

    // Load datapath. cnt wraps naturally from 7 to 0 on the eighth accept.
    // Registers are deliberately not cleared between batches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 3'd0;
            regs <= '0;
        end else if (accept) begin
            regs[cnt] <= in_data;
            cnt       <= cnt + 3'd1;
        end
    end

    // Result capture. The finder's registered output is valid in WAIT; it is
    // forwarded untouched, including the held value the finder keeps on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resData  <= '0;
            resValid <= 1'b0;
        end else if (state == WAIT) begin
            resData  <= op_result;
            resValid <= 1'b1;
        end else if (state == DONE && res_ready) begin
            resValid <= 1'b0;
        end
    end

    assign res_data  = resData;
    assign res_valid = resValid;

    assign reg_out0 = regs[0];
    assign reg_out1 = regs[1];
    assign reg_out2 = regs[2];
    assign reg_out3 = regs[3];
    assign reg_out4 = regs[4];
    assign reg_out5 = regs[5];
    assign reg_out6 = regs[6];
    assign reg_out7 = regs[7];

`ifdef REG_READBACK_EN
    assign rd_data = regs[rd_addr];
`endif

endmodule

// File: tb/tb_max_reg_loader.sv
`timescale 1ns/1ps
module tb_max_reg_loader;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] reg_out0, reg_out1, reg_out2, reg_out3;
    logic [W-1:0] reg_out4, reg_out5, reg_out6, reg_out7;
    logic         op_enable;
    logic [W-1:0] op_result;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         busy;
    logic [2:0]   rd_addr;
`ifdef REG_READBACK_EN
    logic [W-1:0] rd_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    max_reg_loader #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .reg_out0(reg_out0), .reg_out1(reg_out1), .reg_out2(reg_out2), .reg_out3(reg_out3),
        .reg_out4(reg_out4), .reg_out5(reg_out5), .reg_out6(reg_out6), .reg_out7(reg_out7),
        .op_enable(op_enable), .op_result(op_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
`ifdef REG_READBACK_EN
        , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
    );

    logic [7:0][W-1:0] ro;
    assign ro = {reg_out7, reg_out6, reg_out5, reg_out4,
                 reg_out3, reg_out2, reg_out1, reg_out0};

    // Behavioural max-finder: registers the maximum on enable, but only when
    // it is strictly unique; on a tie it keeps its previous output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_result <= '0;
        end else if (op_enable) begin
            logic [W-1:0] m;
            int           n;
            m = ro[0];
            for (int i = 1; i < 8; i++) if (ro[i] > m) m = ro[i];
            n = 0;
            for (int i = 0; i < 8; i++) if (ro[i] == m) n++;
            if (n == 1) op_result <= m;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [7:0][W-1:0] exp);
        for (int i = 0; i < 8; i++) chk($sformatf("%s[%0d]", tag, i), ro[i], exp[i]);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
    endtask

`ifdef REG_READBACK_EN
    task automatic sweep(input string tag, input logic [7:0][W-1:0] exp);
        for (int i = 0; i < 8; i++) begin
            rd_addr = i[2:0];
            #0.4;
            chk($sformatf("%s_rd%0d", tag, i), rd_data, exp[i]);
        end
    endtask
`endif

    logic [7:0][W-1:0] b1, bTie, bGap, bRst;

    initial begin
        b1   = {32'd5, 32'd8, 32'd2, 32'd7, 32'd4, 32'd1, 32'd9, 32'd3};
        bTie = {8{32'h55}};
        for (int i = 0; i < 8; i++) bGap[i] = 32'h10 + i;
        bRst = '0;
        bRst[0] = 32'hFFFF_FFFF;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0; rd_addr = '0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_op_enable", {31'd0, op_enable}, 0);
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk_regs("rst_reg", '0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Batch 1 back-to-back, then backpressure in DONE.
        for (int i = 0; i < 7; i++) load(b1[i]);
        chk("b1_busy_before_last", {31'd0, busy}, 0);
        load(b1[7]);
        chk("b1_fire_in_ready", {31'd0, in_ready}, 0);
        chk("b1_fire_op_enable", {31'd0, op_enable}, 1);
        chk("b1_fire_busy", {31'd0, busy}, 1);
`ifdef REG_READBACK_EN
        sweep("fire", b1);
`endif
        in_valid = 1'b1; in_data = 32'h55; res_ready = 1'b0;
        tick();
        chk("b1_wait_op_enable", {31'd0, op_enable}, 0);
        chk("b1_wait_in_ready", {31'd0, in_ready}, 0);
        chk("b1_wait_res_valid", {31'd0, res_valid}, 0);
`ifdef REG_READBACK_EN
        sweep("wait", b1);
`endif
        tick();
        chk("b1_done_res_valid", {31'd0, res_valid}, 1);
        chk("b1_done_res_data", res_data, 9);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d_res_valid", c), {31'd0, res_valid}, 1);
            chk($sformatf("bp%0d_res_data", c), res_data, 9);
            chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 0);
            chk($sformatf("bp%0d_op_enable", c), {31'd0, op_enable}, 0);
        end
        chk_regs("b1_reg", b1);
`ifdef REG_READBACK_EN
        sweep("done", b1);
`endif
        res_ready = 1'b1;
        tick();
        chk("b1_ret_in_ready", {31'd0, in_ready}, 1);
        chk("b1_ret_res_valid", {31'd0, res_valid}, 0);
        chk("b1_ret_reg0_untouched", reg_out0, 3);
`ifdef REG_READBACK_EN
        sweep("load", b1);
`endif

        // Tie batch: the held word is the first accept; finder keeps 9.
        for (int i = 0; i < 7; i++) load(bTie[i]);
        chk("tie_still_loading", {31'd0, in_ready}, 1);
        load(bTie[7]);
        chk("tie_fire_op_enable", {31'd0, op_enable}, 1);
        in_valid = 1'b0;
        tick();
        tick();
        chk("tie_res_valid", {31'd0, res_valid}, 1);
        chk("tie_res_data", res_data, 9);
        chk_regs("tie_reg", bTie);
        tick();
        chk("tie_ret_in_ready", {31'd0, in_ready}, 1);

        // Gapped input: idle cycles between accepts must not advance cnt.
        for (int i = 0; i < 8; i++) begin
            load(bGap[i]);
            if (i < 7) begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
                tick();
                chk($sformatf("gap%0d_busy", i), {31'd0, busy}, 0);
            end
        end
        chk("gap_fire_op_enable", {31'd0, op_enable}, 1);
        in_valid = 1'b0;
        tick();
        tick();
        chk("gap_res_valid", {31'd0, res_valid}, 1);
        chk("gap_res_data", res_data, 32'h17);
        chk_regs("gap_reg", bGap);
        tick();

        // Asynchronous reset mid-batch.
        for (int i = 0; i < 4; i++) load(32'hA0 + i);
        in_valid = 1'b0;
        chk("pre_rst_reg3", reg_out3, 32'hA3);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 1);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_res_valid", {31'd0, res_valid}, 0);
        chk("arst_res_data", res_data, 0);
        chk("arst_op_enable", {31'd0, op_enable}, 0);
        chk_regs("arst_reg", '0);
        #2;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) load(bRst[i]);
        chk("post_rst_loading", {31'd0, in_ready}, 1);
        load(bRst[7]);
        chk("post_rst_fire", {31'd0, op_enable}, 1);
        in_valid = 1'b0;
        tick();
        tick();
        chk("post_rst_res_valid", {31'd0, res_valid}, 1);
        chk("post_rst_res_data", res_data, 32'hFFFF_FFFF);
        chk_regs("post_rst_reg", bRst);
        tick();
        chk("post_rst_ret", {31'd0, in_ready}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
